// File: rtl/router_src_arbiter.sv
// Packet-granular round-robin arbiter sharing the router input port between sources.
// Define ARB_LEN_CHECK_EN to build the header-length overrun check (len_err).
module router_src_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int GRANT_TMO  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC-1:0]            src_pkt_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_grant,
    output logic [NUM_SRC-1:0]            src_busy,
    input  logic                          rtr_busy,
    output logic                          rtr_pkt_valid,
    output logic [DATA_WIDTH-1:0]         rtr_data,
    output logic                          len_err
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TW = $clog2(GRANT_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(GRANT_TMO - 1);

    typedef enum logic [1:0] {IDLE, GRANT, PKT, GAP} state_t;

    state_t                state;
    logic [GW-1:0]         g;
    logic [GW-1:0]         ptr;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         cand;
    logic [TW-1:0]         tmo;
    logic                  active;
    logic                  cur_valid;
    logic                  cur_req;
    logic                  overrun;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign active    = (state == GRANT) || (state == PKT);
    assign cur_valid = src_pkt_valid[g];
    assign cur_req   = src_req[g];
    assign cur_data  = data_arr[g];

    // Walk from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = GW'((int'(ptr) + k) % NUM_SRC);
            if (src_req[cand]) begin
                pick = cand;
            end
        end
    end

`ifdef ARB_LEN_CHECK_EN
    logic [5:0] remaining;

    assign overrun = (state == PKT) && cur_valid && (remaining == 6'd0);
    assign len_err = overrun && !rtr_busy;
`else
    assign overrun = 1'b0;
    assign len_err = 1'b0;
`endif

    assign rtr_pkt_valid = active && cur_valid && !overrun;
    assign rtr_data      = active ? cur_data : '0;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_busy[i] = (active && (g == GW'(i))) ? rtr_busy : 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            g         <= '0;
            ptr       <= GW'(NUM_SRC - 1);
            tmo       <= '0;
            src_grant <= '0;
`ifdef ARB_LEN_CHECK_EN
            remaining <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((|src_req) && !rtr_busy) begin
                        g         <= pick;
                        ptr       <= pick;
                        tmo       <= '0;
                        src_grant <= NUM_SRC'(1) << pick;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (cur_valid && !rtr_busy) begin
                        state <= PKT;
`ifdef ARB_LEN_CHECK_EN
                        remaining <= cur_data[7:2];
`endif
                    end else if (!cur_req || (!cur_valid && tmo == TMO_LAST)) begin
                        src_grant <= '0;
                        state     <= IDLE;
                    end else if (tmo != TMO_LAST) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                PKT: begin
                    // An overrun byte is closed out exactly like a parity byte.
                    if (!rtr_busy) begin
                        if (!cur_valid || overrun) begin
                            src_grant <= '0;
                            state     <= GAP;
                        end
`ifdef ARB_LEN_CHECK_EN
                        else begin
                            remaining <= remaining - 6'd1;
                        end
`endif
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    src_grant <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
